// File: rtl/game_pkg.sv
// Shared game-wide types and widths for the spawn scheduler and its arbiter.
package game_pkg;

  localparam int COORD_W = 10;
  localparam int LEVEL_W = 3;
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READY = 2'd1,
    ST_GAP   = 2'd2
  } sched_state_t;

  // Requester slots on the two-way arbiter
  localparam int REQ_OBS = 0;
  localparam int REQ_GRN = 1;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter: one-hot combinational grant, the pointer
// moves away from whoever won when the grant is taken (advance).
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  // 0: slot 0 wins a tie, 1: slot 1 wins a tie
  logic r_prio;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = r_prio ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio <= 1'b0;
    end else if (advance && (gnt != 2'b00)) begin
      r_prio <= gnt[0];
    end
  end

endmodule

// File: rtl/spawn_scheduler.sv
// Spawn scheduler: hands out one respawn per game tick with a forced idle gap.
// Difficulty stepping is built only when SPAWN_SCHED_DIFFICULTY_EN is defined.
//
// state    | meaning
// ST_IDLE  | game not running; no grants, gap cleared
// ST_READY | waiting for a tick with an eligible request
// ST_GAP   | counting down game ticks after a grant
module spawn_scheduler
  import game_pkg::*;
#(
  parameter logic [9:0] GAP_TICKS        = 10'd20,
  parameter logic [7:0] LEVEL_SPAWNS     = 8'd8,
  parameter logic [9:0] Y_INITIAL_OFFSET = 10'd50
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               game_en,
  input  logic               run,
  input  logic               obs_req,
  input  logic               grn_req,
  input  logic               holding_max,
  input  logic [9:0]         rand_in,
  output logic               obs_grant,
  output logic               grn_grant,
  output logic [COORD_W-1:0] spawn_y,
  output logic [LEVEL_W-1:0] speed_level
);

  sched_state_t       r_state;
  logic [9:0]         r_gap_cnt;
  logic               r_obs_grant;
  logic               r_grn_grant;
  logic [COORD_W-1:0] r_spawn_y;

  logic [1:0] w_req;
  logic [1:0] w_gnt;
  logic       w_fire;
  logic       w_unused_rand;

  assign w_req[REQ_OBS] = obs_req;
  assign w_req[REQ_GRN] = grn_req & ~holding_max;
  assign w_fire         = (r_state == ST_READY) && run && game_en && (w_gnt != 2'b00);
  assign w_unused_rand  = &{1'b0, rand_in[9:8]};

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst),
    .req     (w_req),
    .advance (w_fire),
    .gnt     (w_gnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_gap_cnt   <= '0;
      r_obs_grant <= 1'b0;
      r_grn_grant <= 1'b0;
      r_spawn_y   <= Y_INITIAL_OFFSET;
    end else begin
      r_obs_grant <= 1'b0;
      r_grn_grant <= 1'b0;
      if (!run) begin
        r_state   <= ST_IDLE;
        r_gap_cnt <= '0;
      end else begin
        case (r_state)
          ST_IDLE: r_state <= ST_READY;
          ST_READY: begin
            if (w_fire) begin
              r_obs_grant <= w_gnt[REQ_OBS];
              r_grn_grant <= w_gnt[REQ_GRN];
              r_spawn_y   <= Y_INITIAL_OFFSET + {2'b00, rand_in[7:0]};
              r_gap_cnt   <= GAP_TICKS;
              // A zero-length gap stays in READY so back-to-back ticks can grant
              r_state     <= (GAP_TICKS == 10'd0) ? ST_READY : ST_GAP;
            end
          end
          ST_GAP: begin
            if (r_gap_cnt == 10'd0) begin
              r_state <= ST_READY;
            end else if (game_en) begin
              r_gap_cnt <= r_gap_cnt - 10'd1;
              if (r_gap_cnt == 10'd1) begin
                r_state <= ST_READY;
              end
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign obs_grant = r_obs_grant;
  assign grn_grant = r_grn_grant;
  assign spawn_y   = r_spawn_y;

`ifdef SPAWN_SCHED_DIFFICULTY_EN
  logic [7:0]         r_spawn_cnt;
  logic [LEVEL_W-1:0] r_speed_level;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_spawn_cnt   <= '0;
      r_speed_level <= '0;
    end else if (w_fire) begin
      if (r_spawn_cnt == LEVEL_SPAWNS - 8'd1) begin
        r_spawn_cnt <= '0;
        if (r_speed_level != LEVEL_MAX) begin
          r_speed_level <= r_speed_level + 3'd1;
        end
      end else begin
        r_spawn_cnt <= r_spawn_cnt + 8'd1;
      end
    end
  end

  assign speed_level = r_speed_level;
`else
  assign speed_level = '0;
`endif

endmodule

// File: tb/tb_spawn_scheduler.sv
// Directed bench for spawn_scheduler with a tick-level reference model and a
// per-cycle compare process.
module tb_spawn_scheduler;

  localparam logic [9:0] GAP  = 10'd20;
  localparam logic [7:0] LVLS = 8'd8;
  localparam logic [9:0] YOFF = 10'd50;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       game_en = 1'b0;
  logic       run = 1'b0;
  logic       obs_req = 1'b0;
  logic       grn_req = 1'b0;
  logic       holding_max = 1'b0;
  logic [9:0] rand_in = '0;
  logic       obs_grant, grn_grant;
  logic [9:0] spawn_y;
  logic [2:0] speed_level;

  always #5 clk = ~clk;

  spawn_scheduler #(
    .GAP_TICKS(GAP), .LEVEL_SPAWNS(LVLS), .Y_INITIAL_OFFSET(YOFF)
  ) dut (
    .clk(clk), .rst(rst), .game_en(game_en), .run(run),
    .obs_req(obs_req), .grn_req(grn_req), .holding_max(holding_max),
    .rand_in(rand_in), .obs_grant(obs_grant), .grn_grant(grn_grant),
    .spawn_y(spawn_y), .speed_level(speed_level)
  );

  int n_assert = 0;
  int n_fail   = 0;

`ifdef SPAWN_SCHED_DIFFICULTY_EN
  localparam int DIFF_ON = 1;
`else
  localparam int DIFF_ON = 0;
`endif

  // Reference model: tick-counted gap, alternating tie winner, level from grant total
  int         m_total = 0;
  int         m_wait = 0;
  bit         m_active = 0;
  bit         m_last_grn = 1;
  bit         m_eo, m_eg, m_pick_grn;
  logic       exp_og = 0, exp_gg = 0;
  logic [9:0] exp_y = YOFF;
  logic [2:0] exp_lvl = 0;

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_total = 0; m_wait = 0; m_active = 0; m_last_grn = 1;
        exp_og = 0; exp_gg = 0; exp_y = YOFF;
      end else begin
        exp_og = 0; exp_gg = 0;
        if (!run) begin
          m_active = 0; m_wait = 0;
        end else if (!m_active) begin
          m_active = 1;
        end else if (game_en) begin
          if (m_wait > 0) begin
            m_wait = m_wait - 1;
          end else begin
            m_eo = obs_req;
            m_eg = grn_req && !holding_max;
            if (m_eo || m_eg) begin
              m_pick_grn = (m_eo && m_eg) ? !m_last_grn : m_eg;
              m_last_grn = m_pick_grn;
              exp_og = !m_pick_grn;
              exp_gg = m_pick_grn;
              exp_y = 10'(int'(YOFF) + (int'(rand_in) % 256));
              m_wait = int'(GAP);
              m_total = m_total + 1;
            end
          end
        end
      end
      if (DIFF_ON != 0) exp_lvl = 3'((m_total / int'(LVLS)) > 7 ? 7 : (m_total / int'(LVLS)));
      else exp_lvl = 3'd0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("cmp_obs_grant", 32'(obs_grant), 32'(exp_og));
    check("cmp_grn_grant", 32'(grn_grant), 32'(exp_gg));
    check("cmp_spawn_y", 32'(spawn_y), 32'(exp_y));
    check("cmp_speed_level", 32'(speed_level), 32'(exp_lvl));
  end

  task automatic cyc(input bit en);
    @(posedge clk); #2; game_en = en;
  endtask

  task automatic do_tick(output bit o, output bit g);
    cyc(1); cyc(0);
    @(negedge clk);
    o = obs_grant; g = grn_grant;
  endtask

  task automatic do_reset;
    @(posedge clk); #2;
    rst = 0; run = 0; obs_req = 0; grn_req = 0; holding_max = 0; game_en = 0;
    @(posedge clk); #2; rst = 1;
  endtask

  bit o, g;
  int n_gr, cnt;
  int gt[3];
  bit gw[3];

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_obs_grant", 32'(obs_grant), 0);
    check("rst_grn_grant", 32'(grn_grant), 0);
    check("rst_spawn_y", 32'(spawn_y), 50);
    check("rst_speed_level", 32'(speed_level), 0);
    @(posedge clk); #2; rst = 1;

    // single obstacle grant, y from low rand byte
    run = 1; obs_req = 1; rand_in = 10'h3A5;
    cyc(0); cyc(0);
    do_tick(o, g);
    check("t1_obs_grant", 32'(o), 1);
    check("t1_grn_grant", 32'(g), 0);
    check("t1_spawn_y", 32'(spawn_y), 215);
    @(posedge clk); #2; obs_req = 0;
    @(negedge clk);
    check("t1_pulse_width", 32'(obs_grant), 0);
    check("t1_y_held", 32'(spawn_y), 215);

    // both requesting: obs, grn, obs with 20 idle ticks between
    do_reset;
    run = 1; obs_req = 1; grn_req = 1;
    cyc(0); cyc(0);
    n_gr = 0;
    for (int t = 0; t < 50; t++) begin
      rand_in = 10'(t * 37);
      do_tick(o, g);
      if (o || g) begin
        if (n_gr < 3) begin gt[n_gr] = t; gw[n_gr] = g; end
        n_gr++;
      end
    end
    check("t2_grant_count", 32'(n_gr), 3);
    check("t2_first_tick", 32'(gt[0]), 0);
    check("t2_gap_1", 32'(gt[1] - gt[0] - 1), 20);
    check("t2_gap_2", 32'(gt[2] - gt[1] - 1), 20);
    check("t2_winner_0", 32'(gw[0]), 0);
    check("t2_winner_1", 32'(gw[1]), 1);
    check("t2_winner_2", 32'(gw[2]), 0);
    check("t2_last_y", 32'(spawn_y), 68);

    // holding_max masks collectible
    do_reset;
    run = 1; grn_req = 1; holding_max = 1;
    cyc(0); cyc(0);
    cnt = 0;
    for (int t = 0; t < 50; t++) begin
      do_tick(o, g);
      if (o || g) cnt++;
    end
    check("t3_masked_grants", 32'(cnt), 0);
    holding_max = 0;
    do_tick(o, g);
    check("t3_grn_after_unmask", 32'(g), 1);

    // run dropped mid-gap, restored, grant on first tick
    do_reset;
    run = 1; obs_req = 1;
    cyc(0); cyc(0);
    do_tick(o, g);
    check("t4_first_grant", 32'(o), 1);
    cnt = 0;
    for (int t = 0; t < 15; t++) begin
      do_tick(o, g);
      if (o || g) cnt++;
    end
    check("t4_no_grant_in_gap", 32'(cnt), 0);
    @(posedge clk); #2; run = 0;
    cyc(1); cyc(0);
    @(posedge clk); #2; run = 1;
    cyc(0); cyc(0);
    do_tick(o, g);
    check("t4_grant_after_restore", 32'(o), 1);
    obs_req = 0;

    // reset on the grant cycle
    do_reset;
    run = 1; obs_req = 1; rand_in = 10'h0FF;
    cyc(0); cyc(0);
    cyc(1); cyc(0);
    check("t5_grant_up", 32'(obs_grant), 1);
    check("t5_y_loaded", 32'(spawn_y), 305);
    #1; rst = 0;
    #1;
    check("t5_grant_dropped", 32'(obs_grant), 0);
    check("t5_y_reset", 32'(spawn_y), 50);
    check("t5_lvl_reset", 32'(speed_level), 0);
    @(posedge clk); #2; rst = 1;
    @(negedge clk);
    check("t5_no_grant_after", 32'(obs_grant), 0);
    cyc(0);
    do_tick(o, g);
    check("t5_regrant", 32'(o), 1);

    // difficulty stepping and saturation over 72 grants
    do_reset;
    run = 1; obs_req = 1;
    cyc(0); cyc(0);
    n_gr = 0;
    for (int t = 0; t < 1600 && n_gr < 72; t++) begin
      rand_in = 10'(t);
      do_tick(o, g);
      if (o) begin
        n_gr++;
        if (n_gr == 8)  check("t6_lvl_8",  32'(speed_level), DIFF_ON ? 1 : 0);
        if (n_gr == 64) check("t6_lvl_64", 32'(speed_level), DIFF_ON ? 7 : 0);
        if (n_gr == 72) check("t6_lvl_72", 32'(speed_level), DIFF_ON ? 7 : 0);
      end
    end
    check("t6_grant_count", 32'(n_gr), 72);
    obs_req = 0;
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/spawn_scheduler.md
SPAWN_SCHEDULER -- requirements
Module: spawn_scheduler

Interface
REQ-001 SHALL have parameter GAP_TICKS, default 10'd20: game ticks of forced idle after each grant.
REQ-002 SHALL have parameter LEVEL_SPAWNS, default 8'd8: grants per difficulty step.
REQ-003 SHALL have parameter Y_INITIAL_OFFSET, default 10'd50: base added to the spawn Y value.
REQ-004 SHALL have port clk, input, 1: system clock (CLOCK_50), the only clock.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port game_en, input, 1: one-cycle game tick pulse.
REQ-007 SHALL have port run, input, 1: high while the game state is PLAYING.
REQ-008 SHALL have port obs_req, input, 1: obstacle requests a respawn; level-held until granted.
REQ-009 SHALL have port grn_req, input, 1: collectible requests a respawn; level-held until granted.
REQ-010 SHALL have port holding_max, input, 1: player is full; masks grn_req.
REQ-011 SHALL have port rand_in, input, 10: shared random value.
REQ-012 SHALL have port obs_grant, output, 1: one-cycle grant pulse to the obstacle.
REQ-013 SHALL have port grn_grant, output, 1: one-cycle grant pulse to the collectible.
REQ-014 SHALL have port spawn_y, output, 10: Y position for the granted requester.
REQ-015 SHALL have port speed_level, output, 3: difficulty level.

Function
REQ-016 SHALL implement FSM states IDLE, READY and GAP, with encodings taken from the shared package.
REQ-017 SHALL move from any state to IDLE in the next cycle when run=0, clearing gap_cnt; spawn_cnt, speed_level and spawn_y are held.
REQ-018 SHALL move from IDLE to READY on the first cycle with run=1.
REQ-019 SHALL, in READY, issue exactly one grant on a cycle with game_en=1 and at least one eligible request, then enter GAP with gap_cnt=GAP_TICKS.
REQ-020 SHALL treat requests as eligible as follows: obs_req always; grn_req only when holding_max=0.
REQ-021 SHALL, when both requests are eligible, grant by round-robin; the last-granted requester loses the tie, and after reset the obstacle wins.
REQ-022 SHALL register grants: obs_grant or grn_grant is high for exactly the cycle after the deciding tick, and both are never high together.
REQ-023 SHALL load spawn_y = Y_INITIAL_OFFSET + {2'b00, rand_in[7:0]} on the same edge that asserts the grant, and hold it until the next grant.
REQ-024 SHALL, in GAP, decrement gap_cnt on each game_en cycle, enter READY when gap_cnt reaches 0, and issue no grant while in GAP.
REQ-025 SHALL treat GAP_TICKS=0 as skipping GAP, so grants can occur on consecutive ticks.
REQ-026 SHALL increment spawn_cnt on each grant; when spawn_cnt reaches LEVEL_SPAWNS-1 it wraps to 0 and speed_level increments, saturating at 3'd7.
REQ-027 SHALL ignore a request that drops before being granted, with no latching.

Reset
REQ-028 SHALL, when rst=0 (asynchronously): set state=IDLE, gap_cnt=0, spawn_cnt=0, rr pointer=obstacle-priority, obs_grant=0, grn_grant=0, spawn_y=Y_INITIAL_OFFSET, speed_level=0.
REQ-029 SHALL, on reset during GAP or during a grant cycle, drop the grant immediately and issue no grant until run=1 and a new tick occur.

Configuration
REQ-030 SHALL support macro SPAWN_SCHED_DIFFICULTY_EN: when defined, spawn_cnt and speed_level operate per REQ-026.
REQ-031 SHALL, when SPAWN_SCHED_DIFFICULTY_EN is undefined, tie speed_level to 3'd0, remove the spawn_cnt logic, and leave grant behaviour otherwise identical.

Structure
REQ-032 SHALL take from shared package game_pkg: FSM state typedef, COORD_W=10, LEVEL_W=3, LEVEL_MAX=3'd7.
REQ-033 SHALL place the two-requester round-robin logic in sub-module rr_arb2 (inputs req[1:0], advance; outputs one-hot gnt[1:0], with a pointer register).

Verification
REQ-034 SHALL verify: reset, run=1, obs_req=1, tick with rand_in=10'h3A5 -> obs_grant pulses 1 cycle, spawn_y=10'd215.
REQ-035 SHALL verify: obs_req=grn_req=1 held across GAP_TICKS=20 -> grants alternate obs, grn, obs with exactly 20 ticks between them.
REQ-036 SHALL verify: grn_req=1, holding_max=1, 50 ticks -> no grn_grant; clearing holding_max -> grn_grant on the next READY tick.
REQ-037 SHALL verify: with the macro defined and LEVEL_SPAWNS=8, 64 grants -> speed_level=7, and a further 8 grants -> it stays 7; with the macro undefined -> speed_level is always 0.
REQ-038 SHALL verify: run dropped at gap_cnt=5 then restored -> state IDLE then READY, and the grant occurs on the first tick after restore.
REQ-039 SHALL verify: rst asserted on the grant cycle -> grant is 0 that cycle, and all outputs take the REQ-028 values.
